obi_axil_master: RTL and testbench

- AXI4-Lite initiator (master) bridging the cv32e40p OBI data port onto the SoC AXI4-Lite peripheral bus (timer, GPIO, UART slaves).
- Converts one OBI request into one AXI4-Lite read or write transaction; one transaction outstanding at a time.
- Built-in watchdog completes a hung transaction with an OBI error.

---
 rtl/axil_pkg.sv | 17 +
 rtl/axil_watchdog.sv | 27 ++
 rtl/obi_axil_master.sv | 170 +++++++++++++++++
 tb/tb_obi_axil_master.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_pkg.sv
// rtl/axil_pkg.sv - shared AXI4-Lite widths and initiator state encoding
package axil_pkg;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int STRB_W = 4;

   typedef enum logic [2:0] {
      IDLE,
      WR,
      WR_RESP,
      RD_ADDR,
      RD_DATA,
      RESP
   } axil_mst_state_e;

endpackage

// File: rtl/axil_watchdog.sv
// rtl/axil_watchdog.sv - saturating busy-cycle counter with expiry flag
module axil_watchdog #(
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   logic [31:0] count_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else if (clear) begin
         count_q <= '0;
      end else if (enable && (count_q != '1)) begin
         count_q <= count_q + 32'd1;
      end
   end

   // A zero timeout disables expiry; the guard also hides the underflow of TIMEOUT_CYCLES-1.
   assign expire = (TIMEOUT_CYCLES != 0) && enable && (count_q >= (TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/obi_axil_master.sv
// rtl/obi_axil_master.sv - OBI data port to AXI4-Lite initiator, one transaction outstanding
module obi_axil_master
   import axil_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              data_req_i,
   output logic              data_gnt_o,
   input  logic [ADDR_W-1:0] data_addr_i,
   input  logic              data_we_i,
   input  logic [STRB_W-1:0] data_be_i,
   input  logic [DATA_W-1:0] data_wdata_i,
   output logic              data_rvalid_o,
   output logic [DATA_W-1:0] data_rdata_o,
   output logic              data_err_o,
   output logic [ADDR_W-1:0] m_awaddr,
   output logic              m_awvalid,
   input  logic              m_awready,
   output logic [DATA_W-1:0] m_wdata,
   output logic [STRB_W-1:0] m_wstrb,
   output logic              m_wvalid,
   input  logic              m_wready,
   input  logic              m_bvalid,
   output logic              m_bready,
   output logic [ADDR_W-1:0] m_araddr,
   output logic              m_arvalid,
   input  logic              m_arready,
   input  logic [DATA_W-1:0] m_rdata,
   input  logic              m_rvalid,
   output logic              m_rready
);

   axil_mst_state_e   state_q, state_d;
   logic              aw_done_q, aw_done_d;
   logic              w_done_q, w_done_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              err_q, err_d;
   logic [ADDR_W-1:0] addr_q;
   logic [STRB_W-1:0] be_q;
   logic [DATA_W-1:0] wdata_q;
   logic              busy;
   logic              expire;

   assign busy = (state_q == WR) || (state_q == WR_RESP) ||
                 (state_q == RD_ADDR) || (state_q == RD_DATA);

   axil_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (data_gnt_o),
      .enable (busy),
      .expire (expire)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
         addr_q    <= '0;
         be_q      <= '0;
         wdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
         rdata_q   <= rdata_d;
         err_q     <= err_d;
         if (data_gnt_o) begin
            addr_q  <= {data_addr_i[ADDR_W-1:2], 2'b00};
            be_q    <= data_be_i;
            wdata_q <= data_wdata_i;
         end
      end
   end

   // A handshake completing in the expiry cycle is checked first, so it wins over the abort.
   always_comb begin
      state_d       = state_q;
      aw_done_d     = aw_done_q;
      w_done_d      = w_done_q;
      rdata_d       = rdata_q;
      err_d         = err_q;
      data_gnt_o    = 1'b0;
      data_rvalid_o = 1'b0;
      m_awvalid     = 1'b0;
      m_wvalid      = 1'b0;
      m_bready      = 1'b0;
      m_arvalid     = 1'b0;
      m_rready      = 1'b0;
      case (state_q)
         IDLE: begin
            data_gnt_o = data_req_i;
            if (data_req_i) begin
               state_d   = data_we_i ? WR : RD_ADDR;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
            end
         end
         WR: begin
            m_awvalid = !aw_done_q;
            m_wvalid  = !w_done_q;
            aw_done_d = aw_done_q | (m_awvalid & m_awready);
            w_done_d  = w_done_q | (m_wvalid & m_wready);
            if (aw_done_d && w_done_d) begin
               state_d = WR_RESP;
            end else if (expire) begin
               state_d = RESP;
               rdata_d = '0;
               err_d   = 1'b1;
            end
         end
         WR_RESP: begin
            m_bready = 1'b1;
            if (m_bvalid) begin
               state_d = RESP;
               rdata_d = '0;
               err_d   = 1'b0;
            end else if (expire) begin
               state_d = RESP;
               rdata_d = '0;
               err_d   = 1'b1;
            end
         end
         RD_ADDR: begin
            m_arvalid = 1'b1;
            if (m_arready) begin
               state_d = RD_DATA;
            end else if (expire) begin
               state_d = RESP;
               rdata_d = '0;
               err_d   = 1'b1;
            end
         end
         RD_DATA: begin
            m_rready = 1'b1;
            if (m_rvalid) begin
               state_d = RESP;
               rdata_d = m_rdata;
               err_d   = 1'b0;
            end else if (expire) begin
               state_d = RESP;
               rdata_d = '0;
               err_d   = 1'b1;
            end
         end
         RESP: begin
            data_rvalid_o = 1'b1;
            state_d       = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign data_err_o   = (state_q == RESP) && err_q;
   assign data_rdata_o = rdata_q;
   assign m_awaddr     = addr_q;
   assign m_araddr     = addr_q;
   assign m_wdata      = wdata_q;
   assign m_wstrb      = be_q;

endmodule

// File: tb/tb_obi_axil_master.sv
// tb/tb_obi_axil_master.sv - directed self-checking bench for obi_axil_master
module tb_obi_axil_master;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        data_req_i;
   logic        data_gnt_o;
   logic [31:0] data_addr_i;
   logic        data_we_i;
   logic [3:0]  data_be_i;
   logic [31:0] data_wdata_i;
   logic        data_rvalid_o;
   logic [31:0] data_rdata_o;
   logic        data_err_o;
   logic [31:0] m_awaddr;
   logic        m_awvalid;
   logic        m_awready;
   logic [31:0] m_wdata;
   logic [3:0]  m_wstrb;
   logic        m_wvalid;
   logic        m_wready;
   logic        m_bvalid;
   logic        m_bready;
   logic [31:0] m_araddr;
   logic        m_arvalid;
   logic        m_arready;
   logic [31:0] m_rdata;
   logic        m_rvalid;
   logic        m_rready;
   logic [4:0]  axi_v;

   int total  = 0;
   int passed = 0;

   always #5 clk = ~clk;

   assign axi_v = {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready};

   obi_axil_master #(.TIMEOUT_CYCLES(16)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .data_req_i    (data_req_i),
      .data_gnt_o    (data_gnt_o),
      .data_addr_i   (data_addr_i),
      .data_we_i     (data_we_i),
      .data_be_i     (data_be_i),
      .data_wdata_i  (data_wdata_i),
      .data_rvalid_o (data_rvalid_o),
      .data_rdata_o  (data_rdata_o),
      .data_err_o    (data_err_o),
      .m_awaddr      (m_awaddr),
      .m_awvalid     (m_awvalid),
      .m_awready     (m_awready),
      .m_wdata       (m_wdata),
      .m_wstrb       (m_wstrb),
      .m_wvalid      (m_wvalid),
      .m_wready      (m_wready),
      .m_bvalid      (m_bvalid),
      .m_bready      (m_bready),
      .m_araddr      (m_araddr),
      .m_arvalid     (m_arvalid),
      .m_arready     (m_arready),
      .m_rdata       (m_rdata),
      .m_rvalid      (m_rvalid),
      .m_rready      (m_rready)
   );

   task automatic nxt;
      @(posedge clk);
      #1;
   endtask

   task automatic quiet;
      data_req_i   = 1'b0;
      data_we_i    = 1'b0;
      data_addr_i  = 32'h0;
      data_be_i    = 4'h0;
      data_wdata_i = 32'h0;
      m_awready    = 1'b0;
      m_wready     = 1'b0;
      m_bvalid     = 1'b0;
      m_arready    = 1'b0;
      m_rdata      = 32'h0;
      m_rvalid     = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      quiet();
      repeat (2) @(posedge clk);
      @(negedge clk);
      total++;
      if ({axi_v, data_gnt_o, data_rvalid_o, data_err_o} !== 8'h00)
         $display("FAIL reset_ctrl: got %b want 00000000", {axi_v, data_gnt_o, data_rvalid_o, data_err_o});
      else passed++;
      total++;
      if (data_rdata_o !== 32'h0) $display("FAIL reset_rdata: got %h want 0", data_rdata_o);
      else passed++;
      rst_n = 1'b1;
      nxt();
   endtask

   task automatic test_write_basic;
      data_req_i = 1'b1; data_we_i = 1'b1; data_addr_i = 32'h0;
      data_wdata_i = 32'h3; data_be_i = 4'hF; m_awready = 1'b1; m_wready = 1'b1;
      @(negedge clk);
      total++;
      if ({data_gnt_o, axi_v} !== 6'b100000) $display("FAIL wr_grant: got %b want 100000", {data_gnt_o, axi_v});
      else passed++;
      nxt(); data_req_i = 1'b0;
      @(negedge clk);
      total++;
      if (axi_v !== 5'b11000) $display("FAIL wr_valids: got %b want 11000", axi_v);
      else passed++;
      total++;
      if ({m_awaddr, m_wdata, m_wstrb} !== {32'h0, 32'h3, 4'hF})
         $display("FAIL wr_payload: got %h %h %h want 0 3 f", m_awaddr, m_wdata, m_wstrb);
      else passed++;
      nxt(); m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b1;
      @(negedge clk);
      total++;
      if ({axi_v, data_rvalid_o} !== 6'b001000) $display("FAIL wr_bready: got %b want 001000", {axi_v, data_rvalid_o});
      else passed++;
      nxt(); m_bvalid = 1'b0;
      @(negedge clk);
      total++;
      if ({data_rvalid_o, data_err_o, data_rdata_o} !== {2'b10, 32'h0})
         $display("FAIL wr_resp: got %b%b %h want 10 0", data_rvalid_o, data_err_o, data_rdata_o);
      else passed++;
      nxt();
      @(negedge clk);
      total++;
      if ({data_rvalid_o, data_gnt_o, axi_v} !== 7'b0) $display("FAIL wr_after: got %b want 0", {data_rvalid_o, data_gnt_o, axi_v});
      else passed++;
      nxt();
   endtask

   task automatic test_read_basic;
      data_req_i = 1'b1; data_we_i = 1'b0; data_addr_i = 32'h4; m_arready = 1'b1;
      @(negedge clk);
      total++;
      if (data_gnt_o !== 1'b1) $display("FAIL rd_grant: got %b want 1", data_gnt_o);
      else passed++;
      nxt(); data_req_i = 1'b0;
      @(negedge clk);
      total++;
      if ({axi_v, m_araddr} !== {5'b00010, 32'h4}) $display("FAIL rd_ar: got %b %h want 00010 4", axi_v, m_araddr);
      else passed++;
      nxt(); m_arready = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h2A;
      @(negedge clk);
      total++;
      if ({axi_v, data_rvalid_o} !== 6'b000010) $display("FAIL rd_rready: got %b want 000010", {axi_v, data_rvalid_o});
      else passed++;
      nxt(); m_rvalid = 1'b0; m_rdata = 32'h0;
      @(negedge clk);
      total++;
      if ({data_rvalid_o, data_err_o, data_rdata_o} !== {2'b10, 32'h2A})
         $display("FAIL rd_resp: got %b%b %h want 10 2a", data_rvalid_o, data_err_o, data_rdata_o);
      else passed++;
      nxt();
      @(negedge clk);
      total++;
      if ({data_rvalid_o, data_rdata_o} !== {1'b0, 32'h2A}) $display("FAIL rd_hold: got %b %h want 0 2a", data_rvalid_o, data_rdata_o);
      else passed++;
      nxt();
   endtask

   task automatic test_write_wready_delay;
      int pulses = 0;
      int bad    = 0;
      data_req_i = 1'b1; data_we_i = 1'b1; data_addr_i = 32'h10;
      data_wdata_i = 32'hDEADBEEF; data_be_i = 4'h3; m_awready = 1'b1; m_wready = 1'b0;
      @(negedge clk);
      nxt(); data_req_i = 1'b0; data_wdata_i = 32'h0; data_be_i = 4'h0;
      @(negedge clk);
      pulses += int'(data_rvalid_o);
      total++;
      if (axi_v !== 5'b11000) $display("FAIL wd_c1: got %b want 11000", axi_v);
      else passed++;
      for (int k = 2; k <= 5; k++) begin
         nxt();
         @(negedge clk);
         pulses += int'(data_rvalid_o);
         if ({axi_v, m_wdata, m_wstrb, m_awaddr} !== {5'b01000, 32'hDEADBEEF, 4'h3, 32'h10}) bad++;
      end
      total++;
      if (bad !== 0) $display("FAIL wd_wait: got %0d bad cycles want 0", bad);
      else passed++;
      nxt(); m_wready = 1'b1;
      @(negedge clk);
      pulses += int'(data_rvalid_o);
      total++;
      if (axi_v !== 5'b01000) $display("FAIL wd_c6: got %b want 01000", axi_v);
      else passed++;
      nxt(); m_wready = 1'b0; m_awready = 1'b0;
      @(negedge clk);
      pulses += int'(data_rvalid_o);
      total++;
      if (axi_v !== 5'b00100) $display("FAIL wd_c7: got %b want 00100", axi_v);
      else passed++;
      nxt(); m_bvalid = 1'b1;
      @(negedge clk);
      pulses += int'(data_rvalid_o);
      nxt(); m_bvalid = 1'b0;
      @(negedge clk);
      pulses += int'(data_rvalid_o);
      total++;
      if ({data_rvalid_o, data_err_o, data_rdata_o} !== {2'b10, 32'h0})
         $display("FAIL wd_resp: got %b%b %h want 10 0", data_rvalid_o, data_err_o, data_rdata_o);
      else passed++;
      nxt();
      @(negedge clk);
      pulses += int'(data_rvalid_o);
      total++;
      if (pulses !== 1) $display("FAIL wd_pulses: got %0d want 1", pulses);
      else passed++;
      nxt();
   endtask

   task automatic test_timeout;
      int arv = 0;
      int pulses = 0;
      data_req_i = 1'b1; data_we_i = 1'b0; data_addr_i = 32'h20; m_arready = 1'b0;
      @(negedge clk);
      for (int k = 1; k <= 16; k++) begin
         nxt();
         data_req_i = 1'b0;
         @(negedge clk);
         arv += int'(m_arvalid);
         pulses += int'(data_rvalid_o);
      end
      total++;
      if ({arv, pulses} !== {32'd16, 32'd0}) $display("FAIL to_busy: got arvalid %0d rvalid %0d want 16 0", arv, pulses);
      else passed++;
      nxt(); m_rvalid = 1'b1; m_rdata = 32'hBAD;
      @(negedge clk);
      total++;
      if ({axi_v, data_rvalid_o, data_err_o, data_rdata_o} !== {7'b0000011, 32'h0})
         $display("FAIL to_resp: got %b %h want 0000011 0", {axi_v, data_rvalid_o, data_err_o}, data_rdata_o);
      else passed++;
      nxt();
      @(negedge clk);
      total++;
      if ({axi_v, data_rvalid_o, data_err_o} !== 7'b0) $display("FAIL to_late: got %b want 0", {axi_v, data_rvalid_o, data_err_o});
      else passed++;
      nxt(); m_rvalid = 1'b0; m_rdata = 32'h0;
      data_req_i = 1'b1; data_addr_i = 32'h8; m_arready = 1'b1;
      @(negedge clk);
      total++;
      if (data_gnt_o !== 1'b1) $display("FAIL to_regrant: got %b want 1", data_gnt_o);
      else passed++;
      nxt(); data_req_i = 1'b0;
      nxt(); m_arready = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h55;
      nxt(); m_rvalid = 1'b0; m_rdata = 32'h0;
      @(negedge clk);
      total++;
      if ({data_rvalid_o, data_err_o, data_rdata_o} !== {2'b10, 32'h55})
         $display("FAIL to_next: got %b%b %h want 10 55", data_rvalid_o, data_err_o, data_rdata_o);
      else passed++;
      nxt();
   endtask

   task automatic test_back_to_back;
      logic [31:0] addrs [2] = '{32'h7, 32'hB};
      logic [31:0] aexp  [2] = '{32'h4, 32'h8};
      logic [31:0] dats  [2] = '{32'h11, 32'h22};
      logic [3:0]  g;
      data_req_i = 1'b1; data_we_i = 1'b0; m_arready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         data_addr_i = addrs[i];
         m_rvalid = 1'b0;
         @(negedge clk); g[3] = data_gnt_o;
         nxt();
         @(negedge clk); g[2] = data_gnt_o;
         total++;
         if (m_araddr !== aexp[i]) $display("FAIL b2b_araddr%0d: got %h want %h", i, m_araddr, aexp[i]);
         else passed++;
         nxt(); m_rvalid = 1'b1; m_rdata = dats[i];
         @(negedge clk); g[1] = data_gnt_o;
         nxt(); m_rvalid = 1'b0; m_rdata = 32'h0;
         @(negedge clk); g[0] = data_gnt_o;
         total++;
         if ({data_rvalid_o, data_rdata_o} !== {1'b1, dats[i]})
            $display("FAIL b2b_resp%0d: got %b %h want 1 %h", i, data_rvalid_o, data_rdata_o, dats[i]);
         else passed++;
         total++;
         if (g !== 4'b1000) $display("FAIL b2b_gnt%0d: got %b want 1000", i, g);
         else passed++;
         nxt();
      end
      data_req_i = 1'b0; m_arready = 1'b0;
   endtask

   task automatic test_reset_mid;
      int stray = 0;
      data_req_i = 1'b1; data_we_i = 1'b1; data_addr_i = 32'h30;
      data_wdata_i = 32'h1; data_be_i = 4'hF; m_awready = 1'b1; m_wready = 1'b1;
      nxt(); data_req_i = 1'b0;
      nxt(); m_awready = 1'b0; m_wready = 1'b0;
      @(negedge clk);
      total++;
      if (axi_v !== 5'b00100) $display("FAIL rst_pre: got %b want 00100", axi_v);
      else passed++;
      #2 rst_n = 1'b0;
      #1;
      total++;
      if ({axi_v, data_gnt_o, data_rvalid_o, data_err_o} !== 8'h00)
         $display("FAIL rst_mid: got %b want 0", {axi_v, data_gnt_o, data_rvalid_o, data_err_o});
      else passed++;
      @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      nxt(); m_bvalid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         stray += int'(data_rvalid_o) + int'(axi_v != 5'b0);
         nxt(); m_bvalid = 1'b0;
      end
      total++;
      if (stray !== 0) $display("FAIL rst_stray: got %0d want 0", stray);
      else passed++;
      data_req_i = 1'b1; data_we_i = 1'b0; data_addr_i = 32'h40;
      @(negedge clk);
      total++;
      if (data_gnt_o !== 1'b1) $display("FAIL rst_idle_gnt: got %b want 1", data_gnt_o);
      else passed++;
      nxt(); data_req_i = 1'b0;
   endtask

   initial begin
      test_reset();
      test_write_basic();
      test_read_basic();
      test_write_wready_delay();
      test_timeout();
      test_back_to_back();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
